// File: rtl/char_fill_ctrl_pkg.sv
// Shared definitions for the text-buffer fill controller: FSM states,
// LCG constants, the LCG step function and a ceiling-log2 helper.
// Pure declarations; no ports, no latency, no flow control.
package char_fill_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam logic [31:0] lcg_mult = 32'd1664525;
    localparam logic [31:0] lcg_inc  = 32'd1013904223;

    // One generator step, modulo 2**32 by truncation to 32 bits.
    function automatic logic [31:0] lcg_next(input logic [31:0] r);
        return r * lcg_mult + lcg_inc;
    endfunction

    // Ceiling log2, never less than 1 so that derived buses stay legal.
    function automatic int clog2(input int value);
        int v;
        int result;
        v      = value - 1;
        result = 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/char_lcg.sv
// 32-bit linear congruential character generator with seed load and step.
// Latency: char_code reflects the current state combinationally; updates on the next edge.
// Backpressure: state only moves when step is high, so a stalled consumer sees a stable code.
// Ports: clk, reset (async active-low), load/seed (reload), step (advance), char_code (masked low bits).
module char_lcg
    import char_fill_ctrl_pkg::*;
#(
    parameter int          char_width   = 8,
    parameter int          num_of_chars = 128,
    parameter logic [31:0] reset_seed   = 32'd1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [31:0]           seed,
    output logic [char_width-1:0] char_code
);

    // num_of_chars is a power of two, so masking keeps codes below it.
    localparam logic [char_width-1:0] char_mask = char_width'(num_of_chars - 1);

    logic [31:0] r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r <= reset_seed;
        end else if (load) begin
            r <= seed;
        end else if (step) begin
            r <= lcg_next(r);
        end
    end

    assign char_code = r[char_width-1:0] & char_mask;

endmodule

// File: rtl/char_fill_ctrl.sv
// Fills the text buffer (whole screen or one row) with pseudo-random characters.
// Latency: one write offered per cycle in FILL; done pulses one cycle after the last accepted write.
// Backpressure: wr_ready low holds wr_addr/wr_data and freezes address counter and generator.
// Ports: clk, reset (async active-low), start/mode/row_sel (request), abort,
//        wr_ready/wr_en/wr_addr/wr_data (buffer write port), busy, done.
module char_fill_ctrl
    import char_fill_ctrl_pkg::*;
#(
    parameter int          char_width   = 8,
    parameter int          num_of_chars = 128,
    parameter int          cols         = 128,
    parameter int          rows         = 48,
    parameter logic [31:0] rand_seed    = 32'd1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             mode,
    input  logic [clog2(rows)-1:0]           row_sel,
    input  logic                             abort,
    input  logic                             wr_ready,
    output logic                             wr_en,
    output logic [clog2(cols*rows)-1:0]      wr_addr,
    output logic [char_width-1:0]            wr_data,
    output logic                             busy,
    output logic                             done
);

    localparam int row_w  = clog2(rows);
    localparam int addr_w = clog2(cols * rows);

    localparam logic [row_w-1:0]  row_max    = row_w'(rows - 1);
    localparam logic [addr_w-1:0] cols_a     = addr_w'(cols);
    localparam logic [addr_w-1:0] screen_end = addr_w'(cols * rows - 1);

    fill_state_t state;
    fill_state_t state_nxt;

    logic                  start_fill;
    logic                  accept;
    logic                  mode_q;
    logic [row_w-1:0]      row_q;
    logic [row_w-1:0]      row_clamp;
    logic [addr_w-1:0]     addr_cnt;
    logic [addr_w-1:0]     start_addr;
    logic [addr_w-1:0]     last_addr;
    logic [char_width-1:0] lcg_char;

    // Out-of-range rows land on the bottom row rather than off the buffer.
    assign row_clamp  = (row_sel > row_max) ? row_max : row_sel;
    assign start_addr = mode ? (addr_w'(row_clamp) * cols_a) : '0;
    assign last_addr  = mode_q ? (addr_w'(row_q) * cols_a + cols_a - addr_w'(1)) : screen_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_fill = 1'b0;
        accept     = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    state_nxt  = FILL;
                    start_fill = 1'b1;
                end
            end
            FILL: begin
                wr_en  = 1'b1;
                busy   = 1'b1;
                accept = wr_ready;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (wr_ready && (addr_cnt == last_addr)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_cnt <= '0;
            mode_q   <= 1'b0;
            row_q    <= '0;
        end else if (start_fill) begin
            addr_cnt <= start_addr;
            mode_q   <= mode;
            row_q    <= row_clamp;
        end else if (accept && (addr_cnt != last_addr)) begin
            // Counter parks on the last cell so no wrapped address is ever held.
            addr_cnt <= addr_cnt + addr_w'(1);
        end
    end

    char_lcg #(
        .char_width   (char_width),
        .num_of_chars (num_of_chars),
        .reset_seed   (rand_seed)
    ) u_lcg (
        .clk       (clk),
        .reset     (reset),
        .load      (start_fill),
        .step      (accept),
        .seed      (rand_seed),
        .char_code (lcg_char)
    );

    // Address and data are only presented while filling; zero otherwise.
    assign wr_addr = (state == FILL) ? addr_cnt : '0;
    assign wr_data = (state == FILL) ? lcg_char : '0;

endmodule

// File: tb/tb_char_fill_ctrl.sv
module tb_char_fill_ctrl;

    localparam int cols  = 128;
    localparam int rows  = 48;
    localparam int cells = cols * rows;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mode;
    logic [5:0]  row_sel;
    logic        abort;
    logic        wr_ready;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    char_fill_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .row_sel  (row_sel),
        .abort    (abort),
        .wr_ready (wr_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference generator: character i of a fill is the masked low byte of the
    // i-th LCG iterate starting from seed 1.
    function automatic logic [31:0] model_step(input logic [31:0] r);
        return r * 32'd1664525 + 32'd1013904223;
    endfunction

    task automatic fill(input bit m, input int row_raw, input int stall_pct, input bit stall10,
                        input int abort_addr, input int reset_addr, input bit rand_start);
        int          row_eff;
        int          first;
        int          last;
        int          exp_addr;
        logic [31:0] r;
        int          cyc;
        int          stalls;
        int          stall_left;
        bit          stalled10;
        bit          finished;
        bit          rdy;

        row_eff  = m ? ((row_raw >= rows) ? rows - 1 : row_raw) : 0;
        first    = row_eff * cols;
        last     = m ? first + cols - 1 : cells - 1;
        exp_addr = first;
        r        = 32'd1;
        cyc      = 1;
        stalls   = 0;
        stall_left = 0;
        stalled10  = 0;
        finished   = 0;

        @(negedge clk);
        start    = 1'b1;
        mode     = m;
        row_sel  = 6'(row_raw);
        abort    = 1'b0;
        wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);

        while (!finished) begin
            if (cyc > 20000) begin
                chk("timeout", 0, 1);
                finished = 1;
            end else if (done) begin
                chk("latency", cyc, (last - first + 1) + stalls + 1);
                chk("done_busy", busy, 0);
                chk("done_wr_en", wr_en, 0);
                start = 1'b0;
                @(negedge clk);
                chk("done_one_cycle", done, 0);
                chk("idle_busy", busy, 0);
                finished = 1;
            end else if (exp_addr > last) begin
                chk("done_missing", done, 1);
                finished = 1;
            end else begin
                chk("wr_en", wr_en, 1);
                chk("wr_addr", wr_addr, exp_addr);
                chk("wr_data", wr_data, r & 32'h7f);
                if (exp_addr == first)     chk("first_data", wr_data, 8'h01);
                if (exp_addr == first + 1) chk("second_data", wr_data, 8'h6c);

                if (exp_addr == reset_addr) begin
                    #2 reset = 1'b0;
                    #1;
                    chk("rst_wr_en", wr_en, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
                    chk("rst_wr_addr", wr_addr, 0);
                    chk("rst_wr_data", wr_data, 0);
                    repeat (3) begin
                        @(negedge clk);
                        chk("rst_no_write", wr_en, 0);
                    end
                    reset = 1'b1;
                    finished = 1;
                end else if (exp_addr == abort_addr) begin
                    abort    = 1'b1;
                    wr_ready = 1'b1;
                    start    = 1'b0;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_wr_en", wr_en, 0);
                    chk("abort_busy", busy, 0);
                    repeat (3) begin
                        chk("abort_no_done", done, 0);
                        @(negedge clk);
                    end
                    finished = 1;
                end else begin
                    if (stall10 && !stalled10 && exp_addr == 10) begin
                        stall_left = 3;
                        stalled10  = 1;
                    end
                    if (stall_left > 0) begin
                        rdy = 0;
                        stall_left--;
                    end else begin
                        rdy = ($urandom_range(99) >= stall_pct);
                    end
                    wr_ready = rdy;
                    start    = rand_start && ($urandom_range(7) == 0);
                    if (rdy) begin
                        exp_addr++;
                        r = model_step(r);
                    end else begin
                        stalls++;
                    end
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        start    = 1'b0;
        wr_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        row_sel  = '0;
        abort    = 1'b0;
        wr_ready = 1'b1;

        #12;
        chk("reset_wr_en", wr_en, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_wr_data", wr_data, 0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // start with abort in IDLE stays idle
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_wr_en", wr_en, 0);

        fill(1'b0, 0, 0, 1'b0, -1, -1, 1'b0);        // full screen, no stalls
        fill(1'b1, 5, 0, 1'b0, -1, -1, 1'b0);        // row 5
        fill(1'b0, 0, 0, 1'b1, 100, -1, 1'b0);       // stall at 10, abort at 100
        fill(1'b0, 0, 0, 1'b0, -1, 2000, 1'b0);      // reset mid-fill
        fill(1'b1, 60, 0, 1'b0, -1, -1, 1'b1);       // clamped row, stray starts
        for (int i = 0; i < 5; i++) begin
            fill(1'b1, $urandom_range(63), 25, 1'b0, -1, -1, 1'b1);
        end
        fill(1'b0, 0, 10, 1'b1, -1, -1, 1'b1);       // full screen with random stalls

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/char_fill_ctrl.md
CHAR_FILL_CTRL -- requirements
Module: char_fill_ctrl

Interface
REQ-001 Parameter char_width, default 8: width of character code written to text buffer.
REQ-002 Parameter num_of_chars, default 128: character set size; SHALL be a power of two not exceeding 2**char_width.
REQ-003 Parameter cols, default 128: text columns (1024 px / 8 px glyph).
REQ-004 Parameter rows, default 48: text rows (768 px / 16 px glyph).
REQ-005 Parameter rand_seed, default 1: generator state after reset and after every start.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  sole clock, rising-edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  single-cycle fill request.
REQ-010 mode  input  1  0 = fill whole screen, 1 = fill one row.
REQ-011 row_sel  input  clog2(rows)  target row for mode 1; values >= rows clamp to rows-1.
REQ-012 abort  input  1  terminate fill in progress.
REQ-013 wr_ready  input  1  text buffer accepts a write this cycle.
REQ-014 wr_en  output  1  write request, valid-style.
REQ-015 wr_addr  output  clog2(cols*rows)  linear cell address, row*cols+col.
REQ-016 wr_data  output  char_width  character code.
REQ-017 busy  output  1  high in FILL.
REQ-018 done  output  1  one-cycle pulse on fill completion.

Function
REQ-019 States: IDLE, FILL, DONE; IDLE after reset.
REQ-020 IDLE: start=1 -> FILL next edge; mode, row_sel latched; generator reloaded with rand_seed; address loaded with 0 (mode 0) or row_sel*cols (mode 1).
REQ-021 FILL: wr_en=1 every cycle; wr_addr, wr_data combinationally from current address counter and generator state.
REQ-022 Write accepted when wr_en & wr_ready; on acceptance address increments by 1 and generator advances one step: r = 1664525*r + 1013904223 mod 2**32.
REQ-023 wr_ready=0: wr_addr, wr_data SHALL hold stable; no counter or generator change.
REQ-024 wr_data = r[char_width-1:0] & (num_of_chars-1); always < num_of_chars.
REQ-025 Last cell (cols*rows-1 in mode 0, row_sel*cols+cols-1 in mode 1) accepted -> DONE; no address wrap-around is ever driven.
REQ-026 DONE: done=1 for exactly one cycle, wr_en=0, then IDLE.
REQ-027 abort=1 in FILL -> IDLE next edge; a write accepted that same cycle still counts; done not asserted.
REQ-028 start while FILL or DONE ignored; start and abort together in IDLE: abort wins, stay IDLE.
REQ-029 busy=1 exactly in FILL; wr_en=0 in IDLE and DONE.
REQ-030 Fill latency: cells + stall cycles + 1 cycle from start to done.

Reset
REQ-031 reset=0 asynchronously forces IDLE, wr_en=0, busy=0, done=0, wr_addr=0, wr_data=0 output registers, generator=rand_seed, even mid-fill.
REQ-032 Deassertion SHALL be synchronised externally; first active edge after release behaves as IDLE.

Structure
REQ-033 Shared package holds state encoding (IDLE/FILL/DONE), LCG constants 1664525 and 1013904223, and clog2 helper.
REQ-034 One sub-module char_lcg: 32-bit LCG with load (seed) and step enable, exposing masked character output.
REQ-035 FSM, address counter and row clamp live in char_fill_ctrl.

Verification
REQ-036 Defaults, start, mode 0, wr_ready=1 -> 6144 writes, addr 0..6143 in order, first wr_data 0x01, second 0x6C, done on cycle 6145 after start.
REQ-037 mode 1, row_sel=5 -> writes addr 640..767 only, then done pulse, busy low.
REQ-038 wr_ready low 3 cycles at addr 10 -> wr_addr=10 and wr_data held 3 cycles, no skipped or duplicate address.
REQ-039 abort at addr 100 with wr_ready=1 -> addr 100 accepted, IDLE next cycle, no done; new start restarts at addr 0 with data 0x01.
REQ-040 reset low mid-fill at addr 2000 -> outputs zero immediately, no further writes; start after release restarts at 0.
REQ-041 mode 1, row_sel=60 -> clamped to row 47, addr 6016..6143; start during FILL ignored.
